// File: rtl/s8sp_pkg.sv
// s8sp_pkg: shared I/O page offsets, timer control bit positions and reset constants
package s8sp_pkg;
   localparam int IO_GPIO_OUT = 0;
   localparam int IO_GPIO_IN  = 1;
   localparam int IO_TMR_CNT  = 2;
   localparam int IO_TMR_CMP  = 3;
   localparam int IO_TMR_CTRL = 4;
   localparam int TMR_EN_BIT   = 0;
   localparam int TMR_FLAG_BIT = 1;
   localparam int TMR_AUTO_BIT = 2;
   localparam logic [15:0] TMR_CMP_RST = 16'hFFFF;
endpackage

// File: rtl/s8sp_io_timer.sv
// s8sp_io_timer: free-running compare timer with enable, sticky match flag and auto-reload
module s8sp_io_timer
   import s8sp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cnt_we,
   input  logic              cmp_we,
   input  logic              ctrl_we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] cnt,
   output logic [DATA_W-1:0] cmp,
   output logic [DATA_W-1:0] ctrl,
   output logic              irq
);
   logic en, flag, auto_rl, match;

   assign match = en && (cnt == cmp);
   assign irq   = flag;

   // control readback: only EN, FLAG and AUTO exist, everything else reads 0
   always_comb begin
      ctrl               = '0;
      ctrl[TMR_EN_BIT]   = en;
      ctrl[TMR_FLAG_BIT] = flag;
      ctrl[TMR_AUTO_BIT] = auto_rl;
   end

   // a core write to the count beats increment/reload; a match beats a software flag clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         cmp     <= DATA_W'(TMR_CMP_RST);
         en      <= 1'b0;
         flag    <= 1'b0;
         auto_rl <= 1'b0;
      end else begin
         cnt  <= cnt_we ? wdata : !en ? cnt : (match && auto_rl) ? '0 : cnt + DATA_W'(1);
         cmp  <= cmp_we ? wdata : cmp;
         flag <= match || (flag && !(ctrl_we && wdata[TMR_FLAG_BIT]));
         if (ctrl_we) begin
            en      <= wdata[TMR_EN_BIT];
            auto_rl <= wdata[TMR_AUTO_BIT];
         end
      end
   end
endmodule

// File: rtl/s8sp_mem_responder.sv
// s8sp_mem_responder: word RAM plus GPIO/timer I/O page behind the core strobes, with a loader port
// Optional timer built only when S8SP_MEM_TIMER_EN is defined.
module s8sp_mem_responder
   import s8sp_pkg::*;
#(
   parameter int                DATA_W  = 16,
   parameter int                ADDR_W  = 8,
   parameter logic [ADDR_W-1:0] IO_BASE = 8'hF0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_mem,
   input  logic              wr_mem,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_err,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [DATA_W-1:0] gpio_in,
   output logic [DATA_W-1:0] gpio_out,
   output logic              timer_irq
);
   localparam logic [ADDR_W-1:0] O_GOUT = ADDR_W'(IO_GPIO_OUT);
   localparam logic [ADDR_W-1:0] O_GIN  = ADDR_W'(IO_GPIO_IN);
   localparam logic [ADDR_W-1:0] O_CNT  = ADDR_W'(IO_TMR_CNT);
   localparam logic [ADDR_W-1:0] O_CMP  = ADDR_W'(IO_TMR_CMP);
   localparam logic [ADDR_W-1:0] O_CTRL = ADDR_W'(IO_TMR_CTRL);
`ifdef S8SP_MEM_TIMER_EN
   localparam bit HAS_TMR = 1'b1;
`else
   localparam bit HAS_TMR = 1'b0;
`endif

   logic [DATA_W-1:0] ram [0:int'(IO_BASE)-1];
   logic [DATA_W-1:0] sync1, sync2, io_rdata, tmr_cnt, tmr_cmp, tmr_ctrl;
   logic [ADDR_W-1:0] off;
   logic is_io, rd_ok, wr_ok, mapped, ld_fire, ld_bad, err_n;

   assign is_io   = mem_addr >= IO_BASE;
   assign off     = mem_addr - IO_BASE;
   assign rd_ok   = rd_mem && !wr_mem;
   assign wr_ok   = wr_mem && !rd_mem;
   assign mapped  = off <= O_GIN || (HAS_TMR && off <= O_CTRL);
   assign ld_ready = reset && !rd_mem && !wr_mem;
   assign ld_fire = ld_valid && ld_ready;
   assign ld_bad  = ld_addr >= IO_BASE;

   // I/O page read mux and the next-cycle error decision
   always_comb begin
      io_rdata  = !mapped ? '0 : off == O_GOUT ? gpio_out : off == O_GIN ? sync2 :
                  off == O_CNT ? tmr_cnt : off == O_CMP ? tmr_cmp : tmr_ctrl;
      mem_rdata = !rd_ok ? '0 : is_io ? io_rdata : ram[mem_addr];
      err_n     = (rd_mem && wr_mem) || (is_io && (rd_ok || wr_ok) && !mapped) ||
                  (wr_ok && is_io && off == O_GIN) || (ld_fire && ld_bad);
   end

   // RAM is not reset, but a write is suppressed while reset is held; core wins over loader
   always_ff @(posedge clk) begin
      if (reset && wr_ok && !is_io) ram[mem_addr] <= mem_wdata;
      else if (ld_fire && !ld_bad) ram[ld_addr] <= ld_data;
   end

   // GPIO output register, two-flop input synchronizer and the error pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpio_out <= '0;
         sync1    <= '0;
         sync2    <= '0;
         mem_err  <= 1'b0;
      end else begin
         gpio_out <= (wr_ok && is_io && off == O_GOUT) ? mem_wdata : gpio_out;
         sync1    <= gpio_in;
         sync2    <= sync1;
         mem_err  <= err_n;
      end
   end

`ifdef S8SP_MEM_TIMER_EN
   s8sp_io_timer #(.DATA_W(DATA_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .cnt_we  (wr_ok && is_io && off == O_CNT),
      .cmp_we  (wr_ok && is_io && off == O_CMP),
      .ctrl_we (wr_ok && is_io && off == O_CTRL),
      .wdata   (mem_wdata),
      .cnt     (tmr_cnt),
      .cmp     (tmr_cmp),
      .ctrl    (tmr_ctrl),
      .irq     (timer_irq)
   );
`else
   assign tmr_cnt   = '0;
   assign tmr_cmp   = '0;
   assign tmr_ctrl  = '0;
   assign timer_irq = 1'b0;
`endif
endmodule

// File: tb/tb_s8sp_mem_responder.sv
// tb_s8sp_mem_responder: table-driven vectors plus sequences for sync, timer and reset abort
module tb_s8sp_mem_responder;
`ifdef S8SP_MEM_TIMER_EN
   localparam bit T = 1'b1;
`else
   localparam bit T = 1'b0;
`endif
   logic clk = 0, reset = 0, rd_mem = 0, wr_mem = 0, ld_valid = 0;
   logic [7:0] mem_addr = 0, ld_addr = 0;
   logic [15:0] mem_wdata = 0, ld_data = 0, gpio_in = 0;
   logic [15:0] mem_rdata, gpio_out;
   logic mem_err, ld_ready, timer_irq;
   int checks = 0, errors = 0;

   typedef struct {
      logic rd, wr; logic [7:0] addr; logic [15:0] wdata;
      logic lv; logic [7:0] la; logic [15:0] ld;
      logic [15:0] e_rdata; logic e_rdy; logic e_err;
   } vec_t;
   vec_t vq[$];

   s8sp_mem_responder dut (
      .clk(clk), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_err(mem_err), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .gpio_in(gpio_in),
      .gpio_out(gpio_out), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic rd, input logic wr, input logic [7:0] a,
                               input logic [15:0] wd, input logic lv, input logic [7:0] la,
                               input logic [15:0] ld, input logic [15:0] er,
                               input logic ery, input logic ee);
      vq.push_back('{rd, wr, a, wd, lv, la, ld, er, ery, ee});
   endfunction

   task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string nm);
      rd_mem = 1; mem_addr = a;
      #1 chk(nm, mem_rdata, exp);
      @(posedge clk); #1;
      rd_mem = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      wr_mem = 1; mem_addr = a; mem_wdata = d;
      @(posedge clk); #1;
      wr_mem = 0;
   endtask

   initial begin
      int n;
      //  rd wr addr   wdata    lv la     ld       rdata    rdy err
      add(0, 0, 8'h00, 16'h0000, 1, 8'h10, 16'h1234, 16'h0000, 1, 0);
      add(1, 0, 8'h10, 16'h0000, 0, 8'h00, 16'h0000, 16'h1234, 0, 0);
      add(0, 1, 8'h20, 16'hBEEF, 1, 8'h30, 16'h5555, 16'h0000, 0, 0);
      add(0, 0, 8'h00, 16'h0000, 1, 8'h30, 16'h5555, 16'h0000, 1, 0);
      add(1, 0, 8'h30, 16'h0000, 0, 8'h00, 16'h0000, 16'h5555, 0, 0);
      add(1, 0, 8'h20, 16'h0000, 0, 8'h00, 16'h0000, 16'hBEEF, 0, 0);
      add(0, 1, 8'hF0, 16'hA5A5, 0, 8'h00, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 8'hF0, 16'h0000, 0, 8'h00, 16'h0000, 16'hA5A5, 0, 0);
      add(0, 1, 8'hF1, 16'h1234, 0, 8'h00, 16'h0000, 16'h0000, 0, 1);
      add(0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 1, 0);
      add(1, 1, 8'h20, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, 1);
      add(1, 0, 8'h20, 16'h0000, 0, 8'h00, 16'h0000, 16'hBEEF, 0, 0);
      add(1, 0, 8'hF8, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, 1);
      add(0, 0, 8'h00, 16'h0000, 1, 8'hF5, 16'h7777, 16'h0000, 1, 1);
      add(1, 0, 8'hFF, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, 1);
      add(1, 0, 8'hF0, 16'h0000, 0, 8'h00, 16'h0000, 16'hA5A5, 0, 0);
      add(1, 0, 8'hF3, 16'h0000, 0, 8'h00, 16'h0000, T ? 16'hFFFF : 16'h0000, 0, !T);
      add(1, 0, 8'hF2, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, !T);
      add(0, 1, 8'hF2, 16'h0007, 0, 8'h00, 16'h0000, 16'h0000, 0, !T);
      add(1, 0, 8'hF2, 16'h0000, 0, 8'h00, 16'h0000, T ? 16'h0007 : 16'h0000, 0, !T);
      add(0, 1, 8'hF2, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, !T);
      add(1, 0, 8'hF4, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, !T);
      add(0, 1, 8'hF4, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, !T);

      #12;
      chk("rst_gpio_out", gpio_out, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_irq", timer_irq, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_rdata", mem_rdata, 0);
      reset = 1;
      @(posedge clk); #1;

      foreach (vq[i]) begin
         rd_mem = vq[i].rd; wr_mem = vq[i].wr; mem_addr = vq[i].addr; mem_wdata = vq[i].wdata;
         ld_valid = vq[i].lv; ld_addr = vq[i].la; ld_data = vq[i].ld;
         #1;
         chk($sformatf("vec%0d_rdata", i), mem_rdata, vq[i].e_rdata);
         chk($sformatf("vec%0d_ld_ready", i), ld_ready, vq[i].e_rdy);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_mem_err", i), mem_err, vq[i].e_err);
      end
      rd_mem = 0; wr_mem = 0; ld_valid = 0;
      chk("gpio_out_held", gpio_out, 16'hA5A5);

      gpio_in = 16'h00FF;
      rd(8'hF1, 16'h0000, "gpio_sync_c0");
      rd(8'hF1, 16'h0000, "gpio_sync_c1");
      rd(8'hF1, 16'h00FF, "gpio_sync_c2");

      if (T) begin
         wr(8'hF3, 16'd5);
         wr(8'hF4, 16'b101);
         n = 0;
         for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (timer_irq) begin n = i; break; end
         end
         chk("irq_delay", n, 6);
         rd(8'hF2, 16'h0000, "cnt_reload");
         repeat (4) @(posedge clk);
         #1;
         wr(8'hF4, 16'b110);
         chk("flag_set_wins", timer_irq, 1);
         rd(8'hF4, 16'h0006, "ctrl_after_clr");
         rd(8'hF2, 16'h0000, "cnt_after_match");
         wr(8'hF4, 16'b010);
         chk("flag_cleared", timer_irq, 0);
         chk("timer_no_err", mem_err, 0);
      end else begin
         chk("irq_tied_low", timer_irq, 0);
      end

      wr_mem = 1; mem_addr = 8'h20; mem_wdata = 16'hDEAD;
      #2 reset = 0;
      #1;
      chk("abort_gpio_out", gpio_out, 0);
      chk("abort_ld_ready", ld_ready, 0);
      chk("abort_mem_err", mem_err, 0);
      @(posedge clk); #1;
      chk("abort_irq", timer_irq, 0);
      reset = 1; wr_mem = 0;
      rd(8'h20, 16'hBEEF, "abort_ram_kept");
      rd(8'hF1, 16'h0000, "abort_sync_clr");
      chk("abort_gpio_after", gpio_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/s8sp_mem_responder.md
# s8sp_mem_responder

Memory-side responder for the S8SP core. It answers the system controller's single-cycle `rd_mem`/`wr_mem` strobes with a word RAM and a small memory-mapped I/O page: GPIO out, synchronized GPIO in, and an optional compare timer. A loader port with a valid/ready handshake lets an external agent fill program RAM whenever the core is not using the bus.

## Interface

Parameters:
- `DATA_W`, 16, data word width
- `ADDR_W`, 8, address width; RAM holds addresses `0` .. `IO_BASE-1`
- `IO_BASE`, 8'hF0, first I/O address; `IO_BASE`..`2^ADDR_W-1` is the I/O page

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `rd_mem`  in  1  core read strobe
- `wr_mem`  in  1  core write strobe
- `mem_addr`  in  ADDR_W  core address (AR or PR on the address bus)
- `mem_wdata`  in  DATA_W  core write data
- `mem_rdata`  out  DATA_W  read data, valid in the same cycle as `rd_mem`
- `mem_err`  out  1  registered one-cycle error pulse
- `ld_valid`  in  1  loader request
- `ld_ready`  out  1  loader may transfer this cycle
- `ld_addr`  in  ADDR_W  loader address
- `ld_data`  in  DATA_W  loader data
- `gpio_in`  in  DATA_W  asynchronous input pins
- `gpio_out`  out  DATA_W  output register
- `timer_irq`  out  1  timer flag (level)

## Operation

RAM behaviour:
- Read is asynchronous; write is synchronous.
- `mem_rdata` is 0 whenever `rd_mem`=0.
- RAM contents are not reset.

I/O map (offset from `IO_BASE`):
- +0 `GPIO_OUT`: read/write.
- +1 `GPIO_IN`: read only; a write is ignored and raises `mem_err`.
- +2 `TMR_CNT`: read/write.
- +3 `TMR_CMP`: read/write.
- +4 `TMR_CTRL`: bit0 `EN`, bit1 `FLAG` (write 1 clears), bit2 `AUTO`; all other bits read 0.
- +5 and up: unmapped. Reads return 0, writes are dropped, `mem_err` is raised.

GPIO input:
- Passes through a 2-flop synchronizer.
- `GPIO_IN` reads the second flop.

Timer:
- When `EN`=1, `TMR_CNT` increments every cycle and wraps 0xFFFF to 0.
- When `EN`=1 and `TMR_CNT`==`TMR_CMP`, `FLAG` sets on the next edge. If `AUTO`=1, the count loads 0 instead of incrementing.
- `timer_irq` = `FLAG`.

Loader:
- `ld_ready` = `reset` & ~`rd_mem` & ~`wr_mem`, combinational.
- A transfer occurs when `ld_valid` & `ld_ready`; it writes RAM at `ld_addr`.
- A loader address ≥ `IO_BASE` is dropped and raises `mem_err`.

Collisions and errors:
- `rd_mem` & `wr_mem` in the same cycle: no write occurs, `mem_rdata`=0, `mem_err` is raised.
- Core access always has priority over the loader.
- A core write to `TMR_CNT` in the same cycle as an increment or reload: the write wins.
- Software clear of `FLAG` in the same cycle as a compare match: the set wins.

## Timing

- Read latency is 0 cycles, because the controller latches IR/AR/DR in the FETCH/EXECUTE cycle of the strobe.
- A write takes effect at the rising edge ending the strobe cycle; a read of the same address in the next cycle returns the new value.
- `mem_err` asserts for exactly one cycle, the cycle after the offending access or transfer.
- `gpio_in` to `GPIO_IN` latency is 2 cycles.
- Compare match at edge N sets `FLAG` (and `timer_irq`) visible after edge N.
- Reset values: `gpio_out`=0, `TMR_CNT`=0, `TMR_CMP`=0xFFFF, `TMR_CTRL`=0, synchronizer flops=0, `mem_err`=0, `timer_irq`=0, `ld_ready`=0.
- Reset asserted mid-access aborts the access; no RAM or register write occurs.

## Configuration

- `S8SP_MEM_TIMER_EN` defined: the timer registers and `timer_irq` are implemented as described.
- `S8SP_MEM_TIMER_EN` undefined: offsets +2..+4 behave as unmapped (read 0, `mem_err` raised) and `timer_irq` is tied to 0.

## Structure

- Shared package `s8sp_pkg` holds:
  - I/O offset constants `IO_GPIO_OUT`, `IO_GPIO_IN`, `IO_TMR_CNT`, `IO_TMR_CMP`, `IO_TMR_CTRL`.
  - `TMR_CTRL` bit positions `TMR_EN_BIT`, `TMR_FLAG_BIT`, `TMR_AUTO_BIT`.
  - `TMR_CMP` reset value.
- One sub-module: `s8sp_io_timer`, holding the counter, compare, control and flag. It is instantiated only under `S8SP_MEM_TIMER_EN`.

## Test plan

- Loader writes 0x1234 to 0x10 with no core strobe → `ld_ready`=1; core `rd_mem` at 0x10 returns 0x1234 in the same cycle.
- Loader `ld_valid` held while `wr_mem`=1 → `ld_ready`=0 and no loader write; the transfer completes in the first idle cycle.
- Core writes 0xA5A5 to 0xF0 → `gpio_out`=0xA5A5 after the edge; read 0xF0 returns 0xA5A5. Write to 0xF1 → `mem_err` pulses once.
- `gpio_in` changes 0→0x00FF → read 0xF1 returns 0 for 2 cycles, then 0x00FF.
- Timer: `TMR_CMP`=5, `TMR_CTRL`=0b101 → `timer_irq` rises 6 cycles after enable and `TMR_CNT` returns to 0. Writing 0b110 to `TMR_CTRL` on a match cycle leaves `FLAG`=1.
- `rd_mem`=`wr_mem`=1 at 0x20 → `mem_rdata`=0, RAM unchanged, `mem_err` pulses. Read 0xF8 → 0 and `mem_err`. Reset asserted mid-write → no RAM change and all outputs at reset values.
